switch_input: RTL
=================

// Module: switch_input
// PURPOSE
//  Memory-mapped input peripheral: the read-side counterpart of the LED output port.
//  Samples 24 board switches and 5 push-buttons, synchronises and debounces them,
//  and latches button presses until software reads them.
//  Returns 16-bit read data to memorio under byte/halfword select strobes.
// PARAMETERS
//  DEBOUNCE_CYCLES  20000  consecutive stable cycles needed before a debounced bit changes (>=2)
// PORTS
//  clk             in   1   system clock
//  rst             in   1   synchronous active-high reset
//  SwitchCtrlLow   in   1   read strobe, switches [7:0]
//  SwitchCtrlMid   in   1   read strobe, switches [15:8]
//  SwitchCtrlHigh  in   1   read strobe, switches [23:16]
//  SwitchCtrlLM    in   1   read strobe, switches [15:0]
//  BtnCtrl         in   1   read strobe, button status (clear-on-read)
//  switch_in       in   24  raw asynchronous switch pins
//  btn_in          in   5   raw asynchronous button pins, active-high
//  switchrdata     out  16  registered read data to memorio
// BEHAVIOUR
//  - Clock is clk; reset is synchronous, active-high on rst; all state clears on the rst edge.
//  - Reset: sync flops, debounce counters, debounced values, btn_pending, switchrdata all 0.
//  - Sync: each raw bit passes a 2-flop synchroniser (reset value 0).
//  - Debounce, per bit: cnt clears whenever sync == deb; else cnt increments;
//    when cnt == DEBOUNCE_CYCLES-1 and sync != deb: deb <= sync, cnt <= 0.
//    Net: input change commits 2 + DEBOUNCE_CYCLES cycles after the raw pin change.
//    A glitch shorter than DEBOUNCE_CYCLES never reaches deb.
//  - Counter width $clog2(DEBOUNCE_CYCLES); no wrap possible (bounded by the compare).
//  - btn_pending[i] sets on deb_btn[i] 0->1 transition (one-cycle rise detect on deb).
//  - Read: one-cycle latency. Strobe in cycle N -> switchrdata valid in cycle N+1.
//    Priority when several strobes are high: Low > Mid > High > LM > Btn.
//    Low  -> {8'h00, deb_sw[7:0]}    Mid -> {8'h00, deb_sw[15:8]}
//    High -> {8'h00, deb_sw[23:16]}  LM  -> deb_sw[15:0]
//    Btn  -> {3'b0, deb_btn[4:0], 3'b0, btn_pending[4:0]}
//    No strobe -> switchrdata <= 16'h0000.
//  - Clear-on-read: a Btn read (winning priority) clears the pending bits it returned.
//    A rise in the same cycle as the clearing read: set wins, bit stays 1.
//    A Btn strobe suppressed by a higher-priority strobe does NOT clear pending.
//  - Strobe held for k cycles: each cycle is a separate read; the 2nd Btn read returns cleared bits.
//  - rst mid-debounce: counts discarded; debounce restarts from 0 against deb=0.
// STRUCTURE
//  - Shared header HEAD.svh: SW_WIDTH=24, BTN_WIDTH=5, Btn read field offsets
//    (level at [12:8], pending at [4:0]).
//  - Sub-module switch_debounce: 1-bit synchroniser + counter + deb register,
//    params DEBOUNCE_CYCLES; instantiated 29x via generate.
//  - Top holds rise detect, btn_pending, read mux and the output register.
// TESTING (DEBOUNCE_CYCLES=4 in the bench)
//  1. rst held 3 cycles with switch_in=24'hFFFFFF -> switchrdata=0, pending=0 on every read.
//  2. switch_in=24'hA5C33C held 8 cycles; strobes Low/Mid/High/LM on consecutive cycles
//     -> 16'h003C, 16'h00C3, 16'h00A5, 16'hC33C, each one cycle after its strobe.
//  3. switch_in[0] pulses 1 for 3 cycles from 0 -> Low read returns bit0=0; 6-cycle hold -> bit0=1.
//  4. btn_in[2] held 10 cycles, then Btn read -> 16'h0404; next Btn read -> 16'h0400;
//     after release and debounce -> 16'h0000.
//  5. btn_in[0] rise commits in the same cycle as a Btn read -> that read shows bit0=0;
//     next read shows pending bit0=1.
//  6. Low+Btn strobed together with pending=5'h01 -> data {8'h00, deb_sw[7:0]}, pending stays 1;
//     rst asserted mid-debounce -> all state 0, no stale commit afterwards.

Source files
------------

// File: rtl/switch_input_pkg.sv
// Shared constants and read-select helper for the switch/button input port.
//   SW_WIDTH / BTN_WIDTH : number of switch and button pins
//   BTN_LVL_LSB          : bit offset of debounced button levels in a Btn read
//   BTN_PEND_LSB         : bit offset of latched button presses in a Btn read
//   rd_select()          : resolves simultaneous read strobes to one source
package switch_input_pkg;
  localparam int SW_WIDTH     = 24;
  localparam int BTN_WIDTH    = 5;
  localparam int IN_WIDTH     = SW_WIDTH + BTN_WIDTH;
  localparam int BTN_LVL_LSB  = 8;
  localparam int BTN_PEND_LSB = 0;

  typedef enum logic [2:0] {
    RD_NONE, RD_LOW, RD_MID, RD_HIGH, RD_LM, RD_BTN
  } rd_sel_e;

  // Fixed priority: Low > Mid > High > LM > Btn
  function automatic rd_sel_e rd_select(input logic lo, input logic mid,
                                        input logic hi, input logic lm,
                                        input logic btn);
    if (lo)       return RD_LOW;
    else if (mid) return RD_MID;
    else if (hi)  return RD_HIGH;
    else if (lm)  return RD_LM;
    else if (btn) return RD_BTN;
    else          return RD_NONE;
  endfunction
endpackage

// File: rtl/switch_debounce.sv
// One-bit synchroniser plus debouncer.
//   clk, rst : clock, synchronous active-high reset
//   raw_i    : asynchronous pin
//   deb_o    : debounced level; follows raw_i only after it has been stable,
//              as seen through the synchroniser, for DEBOUNCE_CYCLES cycles
module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic deb_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_q, sync_q, deb_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
      // Any agreement restarts the run, so the count never exceeds CNT_MAX
      if (sync_q == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        deb_q <= sync_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign deb_o = deb_q;
endmodule

// File: rtl/switch_input.sv
// Memory-mapped switch / push-button input port.
//   clk, rst          : clock, synchronous active-high reset
//   SwitchCtrlLow/Mid/High/LM, BtnCtrl : read strobes (one-cycle read latency)
//   switch_in[23:0]   : raw switch pins
//   btn_in[4:0]       : raw button pins, active-high
//   switchrdata[15:0] : registered read data
// Button presses (debounced rising edges) latch into btn_pending until a
// Btn read that wins priority returns them.
module switch_input
  import switch_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SwitchCtrlLow,
  input  logic                 SwitchCtrlMid,
  input  logic                 SwitchCtrlHigh,
  input  logic                 SwitchCtrlLM,
  input  logic                 BtnCtrl,
  input  logic [SW_WIDTH-1:0]  switch_in,
  input  logic [BTN_WIDTH-1:0] btn_in,
  output logic [15:0]          switchrdata
);
  logic [IN_WIDTH-1:0]  raw_all, deb_all;
  logic [SW_WIDTH-1:0]  deb_sw;
  logic [BTN_WIDTH-1:0] deb_btn;

  assign raw_all = {btn_in, switch_in};

  for (genvar i = 0; i < IN_WIDTH; i++) begin : g_deb
    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw_i (raw_all[i]),
      .deb_o (deb_all[i])
    );
  end

  assign deb_sw  = deb_all[SW_WIDTH-1:0];
  assign deb_btn = deb_all[IN_WIDTH-1:SW_WIDTH];

  logic [BTN_WIDTH-1:0] btn_prev_q, pend_q, pend_d, pend_clr, btn_rise;
  logic [15:0]          rdata_d, rdata_q;
  rd_sel_e              sel;

  assign sel = rd_select(SwitchCtrlLow, SwitchCtrlMid, SwitchCtrlHigh,
                         SwitchCtrlLM, BtnCtrl);

  always_comb begin
    rdata_d  = '0;
    pend_clr = '0;
    unique case (sel)
      RD_LOW:  rdata_d[7:0] = deb_sw[7:0];
      RD_MID:  rdata_d[7:0] = deb_sw[15:8];
      RD_HIGH: rdata_d[7:0] = deb_sw[23:16];
      RD_LM:   rdata_d      = deb_sw[15:0];
      RD_BTN: begin
        rdata_d[BTN_LVL_LSB  +: BTN_WIDTH] = deb_btn;
        rdata_d[BTN_PEND_LSB +: BTN_WIDTH] = pend_q;
        pend_clr = pend_q;  // clear exactly what this read returns
      end
      default: rdata_d = '0;
    endcase
  end

  // A press arriving alongside the clearing read survives: set beats clear
  assign btn_rise = deb_btn & ~btn_prev_q;
  assign pend_d   = (pend_q & ~pend_clr) | btn_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev_q <= '0;
      pend_q     <= '0;
      rdata_q    <= '0;
    end else begin
      btn_prev_q <= deb_btn;
      pend_q     <= pend_d;
      rdata_q    <= rdata_d;
    end
  end

  assign switchrdata = rdata_q;
endmodule
